// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch front-end. Issues word reads to instruction
// memory, buffers returned words with their PCs in an in-order queue and
// presents them to the decoder. A redirect flushes the queue and discards the
// responses still owed to the abandoned stream.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [31:0]     r_fetch_pc;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [PW-1:0]   r_fill;
  logic [CW-1:0]   r_alloc_cnt;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   w_drop_next;
  logic [CW-1:0]   w_outstanding_next;
  logic [31:0]     r_pc   [DEPTH];
  logic [31:0]     r_data [DEPTH];
  logic [DEPTH-1:0] r_filled;

  logic w_grant;
  logic w_rsp;
  logic w_accept;
  logic w_pop;

  // Handshake qualifiers. A response with nothing outstanding belongs to a
  // request issued before the last reset and is ignored entirely.
  assign w_grant  = imem_req & imem_gnt;
  assign w_rsp    = imem_rvalid & (r_outstanding != '0);
  assign w_accept = w_rsp & (r_drop_cnt == '0);
  assign w_pop    = instr_valid & instr_ready;

  // Requests in flight after this edge; on a redirect all of them are stale.
  assign w_outstanding_next = r_outstanding + CW'(w_grant) - CW'(w_rsp);

  // Fetch only once out of BOOT and while a queue slot is free (registered count).
  assign imem_req  = (r_state != S_BOOT) && (r_alloc_cnt < CW'(DEPTH));
  assign imem_addr = r_fetch_pc;

  // Head entry is presented directly from the queue registers.
  assign instr_valid = r_filled[r_head];
  assign instr       = r_data[r_head];
  assign instr_pc    = r_pc[r_head];

  // Next-state and drop-counter logic.
  always_comb begin
    w_state_next = r_state;
    w_drop_next  = r_drop_cnt;
    if (redirect) begin
      w_drop_next  = w_outstanding_next;
      w_state_next = (w_outstanding_next != '0) ? S_FLUSH : S_RUN;
    end else begin
      if (w_rsp && (r_drop_cnt != '0)) begin
        w_drop_next = r_drop_cnt - CW'(1);
      end
      case (r_state)
        S_BOOT:  w_state_next = S_RUN;
        S_FLUSH: if (w_drop_next == '0) w_state_next = S_RUN;
        default: w_state_next = r_state;
      endcase
    end
  end

  // State, pointers, counters and queue entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_BOOT;
      r_fetch_pc    <= RESET_PC;
      r_head        <= '0;
      r_tail        <= '0;
      r_fill        <= '0;
      r_alloc_cnt   <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_filled      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_state       <= w_state_next;
      r_drop_cnt    <= w_drop_next;
      r_outstanding <= w_outstanding_next;
      if (redirect) begin
        // Redirect wins over grant, fill and pop in the same cycle.
        r_fetch_pc  <= redirect_pc & 32'hFFFF_FFFC;
        r_head      <= '0;
        r_tail      <= '0;
        r_fill      <= '0;
        r_alloc_cnt <= '0;
        r_filled    <= '0;
      end else begin
        if (w_grant) begin
          r_pc[r_tail]     <= r_fetch_pc;
          r_filled[r_tail] <= 1'b0;
          r_tail           <= r_tail + PW'(1);
          r_fetch_pc       <= r_fetch_pc + 32'd4;
        end
        if (w_accept) begin
          r_data[r_fill]   <= imem_rdata;
          r_filled[r_fill] <= 1'b1;
          r_fill           <= r_fill + PW'(1);
        end
        if (w_pop) begin
          r_filled[r_head] <= 1'b0;
          r_head           <= r_head + PW'(1);
        end
        r_alloc_cnt <= r_alloc_cnt + CW'(w_grant) - CW'(w_pop);
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue: behavioural instruction memory with adjustable
// latency and an address window it will grant, a scoreboard of expected
// {pc, instr} pairs filled by the directed stimulus, and a monitor that pops
// and compares whenever the decoder side consumes an instruction.
module tb_ifetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  exp_t  exp_q[$];
  mreq_t mem_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat = 1;
  int gnt_count = 0;
  int npops = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;
  int rel_cyc = 0;
  logic [31:0] win_lo = 32'h0;
  logic [31:0] win_hi = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0] ^ 16'h5A5A};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Stimulus changes land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [31:0] start, input int count);
    exp_t e;
    for (int i = 0; i < count; i++) begin
      e.pc   = start + 32'(4 * i);
      e.data = mem_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check({name, "_drained_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Instruction memory: grants requests inside [win_lo, win_hi), answers in
  // order after lat cycles; cleared by reset.
  initial begin
    mreq_t m;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        mem_q.delete();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end else begin
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
          m = mem_q.pop_front();
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(m.addr);
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata  = 32'h0;
        end
        imem_gnt = (imem_addr >= win_lo) && (imem_addr < win_hi);
        if (imem_gnt && imem_req) begin
          m.addr = imem_addr;
          m.due  = cyc + lat;
          mem_q.push_back(m);
          gnt_count++;
        end
      end
    end
  end

  // Monitor: every consumed instruction is checked against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && instr_valid && instr_ready && !redirect) begin
        if (npops == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        npops++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_instr: got pc=%h instr=%h, required no delivery", instr_pc, instr);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e.pc);
          check("instr", instr, e.data);
        end
      end
    end
  end

  initial begin
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    repeat (2) tick();

    // Reset values.
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);

    // Streaming fetch, k=1, decoder always ready.
    win_lo = 32'h0; win_hi = 32'h20; lat = 1; instr_ready = 1'b1;
    push_range(32'h0, 8);
    npops = 0;
    rel_cyc = cyc;
    rst = 1'b1;
    check("boot_no_req", 32'(imem_req), 32'd0);
    tick();
    check("req_after_boot", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    drain("stream");
    check("stream_first_latency", 32'(first_pop_cyc - rel_cyc), 32'd4);
    check("stream_back_to_back", 32'(last_pop_cyc - first_pop_cyc), 32'd7);
    check("stream_next_addr", imem_addr, 32'h20);

    // Decoder stalled: queue fills after exactly DEPTH grants.
    instr_ready = 1'b0; win_lo = 32'h20; win_hi = 32'h40; gnt_count = 0;
    repeat (10) tick();
    check("full_grants", 32'(gnt_count), 32'd4);
    check("full_req", 32'(imem_req), 32'd0);
    check("full_addr", imem_addr, 32'h30);
    check("full_head_valid", 32'(instr_valid), 32'd1);
    check("full_head_pc", instr_pc, 32'h20);
    check("full_head_instr", instr, mem_word(32'h20));
    push_range(32'h20, 8);
    instr_ready = 1'b1;
    drain("full");
    check("full_resume_addr", imem_addr, 32'h40);

    // k=3, two requests outstanding, redirect to an unaligned target.
    instr_ready = 1'b0; lat = 3; win_lo = 32'h40; win_hi = 32'h48;
    tick();
    tick();
    redirect = 1'b1; redirect_pc = 32'h103;
    win_lo = 32'h100; win_hi = 32'h110; lat = 1; instr_ready = 1'b1;
    push_range(32'h100, 4);
    tick();
    redirect = 1'b0;
    check("redir_valid_low", 32'(instr_valid), 32'd0);
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", imem_addr, 32'h100);
    drain("drop2");

    // Redirect in the same cycle as a grant and a response.
    redirect = 1'b1; redirect_pc = 32'h200;
    win_lo = 32'h200; win_hi = 32'h310; lat = 1; instr_ready = 1'b0;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    redirect = 1'b1; redirect_pc = 32'h300; instr_ready = 1'b1;
    push_range(32'h300, 4);
    tick();
    redirect = 1'b0;
    check("same_cycle_valid_low", 32'(instr_valid), 32'd0);
    check("same_cycle_addr", imem_addr, 32'h300);
    drain("same_cycle");

    // Back-to-back redirects: only the second stream is delivered.
    redirect = 1'b1; redirect_pc = 32'h40;
    win_lo = 32'h40; win_hi = 32'h90; lat = 2; instr_ready = 1'b1;
    push_range(32'h80, 4);
    tick();
    redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    drain("b2b");
    check("b2b_idle_req", 32'(imem_req), 32'd1);
    check("b2b_idle_addr", imem_addr, 32'h90);

    // Reset mid-stream: asynchronous return to reset values, refetch from 0.
    instr_ready = 1'b0; win_lo = 32'h90; win_hi = 32'hB0; lat = 2;
    repeat (6) tick();
    check("pre_rst_valid", 32'(instr_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("arst_imem_req", 32'(imem_req), 32'd0);
    check("arst_imem_addr", imem_addr, 32'h0);
    check("arst_instr_valid", 32'(instr_valid), 32'd0);
    check("arst_instr", instr, 32'h0);
    check("arst_instr_pc", instr_pc, 32'h0);
    win_lo = 32'h0; win_hi = 32'h10; lat = 1; instr_ready = 1'b1;
    repeat (3) tick();
    push_range(32'h0, 4);
    rst = 1'b1;
    drain("after_rst");
    check("after_rst_addr", imem_addr, 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
